// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 frame formatter.
// Frame layout, FSM state encoding and the checksum test live here so the
// top and its testbench agree on one definition.
package dht11_pkg;

   localparam int FRAME_W = 40;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      CONV  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Byte order on the wire, MSB first.
   typedef struct packed {
      logic [7:0] hum_i;
      logic [7:0] hum_f;
      logic [7:0] temp_i;
      logic [7:0] temp_f;
      logic [7:0] checksum;
   } frame_t;

   // True when the low 8 bits of the four data bytes' sum equal the checksum byte.
   function automatic logic dht11_checksum(input logic [FRAME_W-1:0] frame);
      frame_t     f;
      logic [7:0] sum;
      f   = frame;
      sum = f.hum_i + f.hum_f + f.temp_i + f.temp_f;
      return (sum == f.checksum);
   endfunction

endpackage

// File: rtl/dht11_frame_formatter_if.sv
// Frame-in / reading-out bundle between the DHT11 controller and the display path.
// master drives frames and watches results; slave is the formatter itself.
// ERR_CNT_W must match the formatter instance it is bound to.
interface dht11_frame_formatter_if #(
   parameter int ERR_CNT_W = 8
);
   import dht11_pkg::*;

   logic                 frame_valid;
   logic [FRAME_W-1:0]   frame;
   logic                 busy;
   logic [7:0]           hum_bin;
   logic [7:0]           temp_bin;
   logic [7:0]           bcd_hum;
   logic [7:0]           bcd_temp;
   logic                 valid;
   logic                 chk_err;
   logic                 range_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output frame_valid, frame,
      input  busy, hum_bin, temp_bin, bcd_hum, bcd_temp,
             valid, chk_err, range_err, err_cnt
   );

   modport slave (
      input  frame_valid, frame,
      output busy, hum_bin, temp_bin, bcd_hum, bcd_temp,
             valid, chk_err, range_err, err_cnt
   );

endinterface

// File: rtl/bin8_to_bcd2.sv
// Iterative double-dabble: one binary byte to two BCD digits, one shift per cycle.
// Latency: start loads, then 8 shift cycles; done is high during the 8th shift.
// No backpressure: start is only honoured by the caller when idle; dout is valid while done.
module bin8_to_bcd2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       done
);

   logic [7:0] bcd_q, bcd_d;
   logic [7:0] bin_q, bin_d;
   logic [2:0] cnt_q, cnt_d;
   logic       active_q, active_d;

   logic [3:0] ones_adj;
   logic [3:0] tens_adj;
   logic [7:0] step_bcd;
   logic       unused_hundreds;

   // One double-dabble step on the current state: add 3 to any digit >= 5, then shift.
   always_comb begin
      ones_adj = (bcd_q[3:0] >= 4'd5) ? (bcd_q[3:0] + 4'd3) : bcd_q[3:0];
      tens_adj = (bcd_q[7:4] >= 4'd5) ? (bcd_q[7:4] + 4'd3) : bcd_q[7:4];
      step_bcd = {tens_adj[2:0], ones_adj, bin_q[7]};
   end

   // The hundreds carry only appears for inputs above 99, which the caller never converts.
   assign unused_hundreds = tens_adj[3];

   // Final digits come straight off the last step so the caller can latch them
   // in the same cycle, without waiting for one more register stage.
   assign dout = step_bcd;
   assign done = active_q && (cnt_q == 3'd7);

   // Load on start, then shift eight times and go idle.
   always_comb begin
      bcd_d    = bcd_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (start) begin
         bcd_d    = 8'h00;
         bin_d    = din;
         cnt_d    = 3'd0;
         active_d = 1'b1;
      end else if (active_q) begin
         bcd_d = step_bcd;
         bin_d = {bin_q[6:0], 1'b0};
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            active_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q    <= 8'h00;
         bin_q    <= 8'h00;
         cnt_q    <= 3'd0;
         active_q <= 1'b0;
      end else begin
         bcd_q    <= bcd_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

endmodule

// File: rtl/dht11_frame_formatter.sv
// Validates DHT11 frames and presents the last good humidity/temperature as binary and 2-digit BCD.
// Latency: frame_valid at edge N -> error pulse at N+2, or valid with new data at N+10.
// No backpressure: frames offered while busy are silently dropped.
module dht11_frame_formatter
   import dht11_pkg::*;
#(
   parameter int ERR_CNT_W = 8,
   parameter int HUM_MAX   = 99,
   parameter int TEMP_MAX  = 99
) (
   input  logic                     clk,
   input  logic                     reset,
   dht11_frame_formatter_if.slave   bus
);

   localparam logic [7:0] HUM_MAX_B  = HUM_MAX[7:0];
   localparam logic [7:0] TEMP_MAX_B = TEMP_MAX[7:0];

   state_t               state_q, state_d;
   frame_t               frame_q, frame_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 chk_err_q, chk_err_d;
   logic                 range_err_q, range_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [ERR_CNT_W-1:0] err_cnt_inc;
   logic [7:0]           hum_bin_q, hum_bin_d;
   logic [7:0]           temp_bin_q, temp_bin_d;
   logic [7:0]           bcd_hum_q, bcd_hum_d;
   logic [7:0]           bcd_temp_q, bcd_temp_d;

   logic                 conv_start;
   logic [7:0]           hum_bcd;
   logic [7:0]           temp_bcd;
   logic                 hum_done;
   logic                 temp_done;

   // Both bytes convert side by side; they always finish together.
   bin8_to_bcd2 u_hum_bcd (
      .clk   (clk),
      .rst_n (reset),
      .start (conv_start),
      .din   (frame_q.hum_i),
      .dout  (hum_bcd),
      .done  (hum_done)
   );

   bin8_to_bcd2 u_temp_bcd (
      .clk   (clk),
      .rst_n (reset),
      .start (conv_start),
      .din   (frame_q.temp_i),
      .dout  (temp_bcd),
      .done  (temp_done)
   );

   // Rejected-frame counter sticks at all-ones instead of wrapping.
   assign err_cnt_inc = (&err_cnt_q) ? err_cnt_q : (err_cnt_q + 1'b1);

   // Next-state and output decode; result registers only move on entry to DONE.
   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      busy_d      = busy_q;
      valid_d     = 1'b0;
      chk_err_d   = 1'b0;
      range_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      hum_bin_d   = hum_bin_q;
      temp_bin_d  = temp_bin_q;
      bcd_hum_d   = bcd_hum_q;
      bcd_temp_d  = bcd_temp_q;
      conv_start  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.frame_valid) begin
               frame_d = bus.frame;
               busy_d  = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // Checksum failure wins over range, so a frame raises at most one error.
            if (!dht11_checksum(frame_q)) begin
               chk_err_d = 1'b1;
               err_cnt_d = err_cnt_inc;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else if ((frame_q.hum_i > HUM_MAX_B) || (frame_q.temp_i > TEMP_MAX_B)) begin
               range_err_d = 1'b1;
               err_cnt_d   = err_cnt_inc;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end else begin
               conv_start = 1'b1;
               state_d    = CONV;
            end
         end
         CONV: begin
            if (hum_done && temp_done) begin
               hum_bin_d  = frame_q.hum_i;
               temp_bin_d = frame_q.temp_i;
               bcd_hum_d  = hum_bcd;
               bcd_temp_d = temp_bcd;
               valid_d    = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // FSM and every registered output; reset clears everything, including any half-done reading.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         chk_err_q   <= 1'b0;
         range_err_q <= 1'b0;
         err_cnt_q   <= '0;
         hum_bin_q   <= 8'h00;
         temp_bin_q  <= 8'h00;
         bcd_hum_q   <= 8'h00;
         bcd_temp_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         chk_err_q   <= chk_err_d;
         range_err_q <= range_err_d;
         err_cnt_q   <= err_cnt_d;
         hum_bin_q   <= hum_bin_d;
         temp_bin_q  <= temp_bin_d;
         bcd_hum_q   <= bcd_hum_d;
         bcd_temp_q  <= bcd_temp_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.valid     = valid_q;
   assign bus.chk_err   = chk_err_q;
   assign bus.range_err = range_err_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.hum_bin   = hum_bin_q;
   assign bus.temp_bin  = temp_bin_q;
   assign bus.bcd_hum   = bcd_hum_q;
   assign bus.bcd_temp  = bcd_temp_q;

endmodule
